// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Byte/halfword/word load-store formatter sitting between the
//               EX/MEM pipeline register and a word-organised data memory.
//               Loads are formatted combinationally; sub-word stores are a
//               two-cycle read-modify-write that stalls the pipeline for the
//               first cycle. Big-endian lanes: offset 0 is bits [31:24].
//               Optional feature macro: MISALIGN_TRAP_EN (misaligned-access
//               trap; when undefined, low offset bits are ignored instead).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] mr,
  input  logic [31:0]   mqb,
  input  logic          mwmem,
  input  logic          mm2reg,
  input  logic [1:0]    msize,
  input  logic          msign,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  input  logic [31:0]   dm_rdata,
  output logic [31:0]   mdo,
  output logic          mstall,
  output logic          maddr_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   merge_q;
  logic [AW-1:0] addr_q;

  logic [1:0]  off;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        in_idle;
  logic        misalign;
  logic        word_st;
  logic        sub_st;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  assign off     = mr[1:0];
  assign is_byte = (msize == 2'b00);
  assign is_half = (msize == 2'b01);
  assign is_word = msize[1];
  assign in_idle = (state == IDLE);

`ifdef MISALIGN_TRAP_EN
  // Words must sit on offset 0, halves on an even offset
  assign misalign = (is_word && (off != 2'b00)) || (is_half && off[0]);
`else
  assign misalign = 1'b0;
`endif

  // Store classification; only sampled in IDLE, RMW_WR ignores new requests
  assign word_st = in_idle && mwmem && is_word && !misalign;
  assign sub_st  = in_idle && mwmem && !is_word && !misalign;

  // Memory-side controls; reset gates the write strobe immediately
  assign mstall    = !rst && sub_st;
  assign dm_we     = !rst && (word_st || (state == RMW_WR));
  assign dm_addr   = in_idle ? {mr[AW-1:2], 2'b00} : addr_q;
  assign dm_wdata  = in_idle ? mqb : merge_q;
  assign maddr_err = !rst && in_idle && (mwmem || mm2reg) && misalign;

  // Select the addressed byte and halfword lanes from the read word
  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0:    byte_sel = dm_rdata[31:24];
      2'd1:    byte_sel = dm_rdata[23:16];
      2'd2:    byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
  end

  // Extend the selected lane according to size and signedness
  always_comb begin
    load_fmt = dm_rdata;
    if (is_byte) begin
      load_fmt = {{24{msign & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_fmt = {{16{msign & half_sel[15]}}, half_sel};
    end
  end

  // Final load result; unformatted read data when no load is in progress
  always_comb begin
    mdo = dm_rdata;
    if (rst) begin
      mdo = 32'h0;
    end else if (in_idle && mm2reg) begin
      mdo = misalign ? 32'h0 : load_fmt;
    end
  end

  // Build the read-modify-write word: replace the addressed lane(s) with store data
  always_comb begin
    merged = dm_rdata;
    if (is_byte) begin
      case (off)
        2'd0:    merged[31:24] = mqb[7:0];
        2'd1:    merged[23:16] = mqb[7:0];
        2'd2:    merged[15:8]  = mqb[7:0];
        default: merged[7:0]   = mqb[7:0];
      endcase
    end else if (is_half) begin
      if (off[1]) begin
        merged[15:0] = mqb[15:0];
      end else begin
        merged[31:16] = mqb[15:0];
      end
    end
  end

  // Two-state RMW sequencer: capture merged word and address, then write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      merge_q <= 32'h0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sub_st) begin
            merge_q <= merged;
            addr_q  <= dm_addr;
            state   <= RMW_WR;
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a behavioural
//               word memory (combinational read, falling-edge write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] mr;
  logic [31:0] mqb;
  logic        mwmem;
  logic        mm2reg;
  logic [1:0]  msize;
  logic        msign;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic [31:0] mdo;
  logic        mstall;
  logic        maddr_err;

  logic [31:0] mem [0:15];

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] C_MDO   = 6'h01;
  localparam logic [5:0] C_WE    = 6'h02;
  localparam logic [5:0] C_STALL = 6'h04;
  localparam logic [5:0] C_ADDR  = 6'h08;
  localparam logic [5:0] C_WDATA = 6'h10;
  localparam logic [5:0] C_ERR   = 6'h20;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] mdo;
    logic        we;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  mem_access_unit #(.AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mr        (mr),
    .mqb       (mqb),
    .mwmem     (mwmem),
    .mm2reg    (mm2reg),
    .msize     (msize),
    .msign     (msign),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_we     (dm_we),
    .dm_rdata  (dm_rdata),
    .mdo       (mdo),
    .mstall    (mstall),
    .maddr_err (maddr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model
  assign dm_rdata = mem[dm_addr[5:2]];
  always @(negedge clk) begin
    if (dm_we) mem[dm_addr[5:2]] <= dm_wdata;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%08h required=%08h", n, act, req);
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation
  always @(posedge clk) begin
    #3;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.mask[0]) chk({cur.name, ".mdo"},   mdo,                cur.mdo);
      if (cur.mask[1]) chk({cur.name, ".we"},    {31'b0, dm_we},     {31'b0, cur.we});
      if (cur.mask[2]) chk({cur.name, ".stall"}, {31'b0, mstall},    {31'b0, cur.stall});
      if (cur.mask[3]) chk({cur.name, ".addr"},  dm_addr,            cur.addr);
      if (cur.mask[4]) chk({cur.name, ".wdata"}, dm_wdata,           cur.wdata);
      if (cur.mask[5]) chk({cur.name, ".err"},   {31'b0, maddr_err}, {31'b0, cur.err});
    end
  end

  // Apply one cycle of inputs just after the rising edge
  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] q,
                       input logic w, input logic l, input logic [1:0] sz, input logic sg);
    @(posedge clk);
    #1;
    rst = r; mr = a; mqb = q; mwmem = w; mm2reg = l; msize = sz; msign = sg;
  endtask

  task automatic expect_o(input string n, input logic [5:0] m, input logic [31:0] o,
                          input logic we, input logic st, input logic [31:0] ad,
                          input logic [31:0] wd, input logic er);
    exp_t e;
    e.name = n; e.mask = m; e.mdo = o; e.we = we; e.stall = st;
    e.addr = ad; e.wdata = wd; e.err = er;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hA00000AA;
    mem[1] = 32'h10000011;
    mem[2] = 32'h20000022;
    mem[3] = 32'h30000033;
    rst = 1'b1; mr = 0; mqb = 0; mwmem = 0; mm2reg = 0; msize = 0; msign = 0;

    // Reset: word store request must be gated
    drive(1, 32'd8, 32'hFFFFFFFF, 1, 0, 2'b10, 0);
    expect_o("reset", C_MDO|C_WE|C_STALL|C_ERR, 32'h0, 0, 0, 0, 0, 0);

    // Loads
    drive(0, 32'd8, 0, 0, 1, 2'b10, 0);
    expect_o("ld_word8", C_MDO|C_WE|C_STALL, 32'h20000022, 0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 1, 2'b00, 1);
    expect_o("ld_b0_s", C_MDO|C_STALL, 32'hFFFFFFA0, 0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 1, 2'b00, 0);
    expect_o("ld_b0_u", C_MDO, 32'h000000A0, 0, 0, 0, 0, 0);
    drive(0, 32'd2, 0, 0, 1, 2'b01, 1);
    expect_o("ld_h2_s", C_MDO, 32'h000000AA, 0, 0, 0, 0, 0);
    drive(0, 32'd3, 0, 0, 1, 2'b00, 1);
    expect_o("ld_b3_s", C_MDO, 32'hFFFFFFAA, 0, 0, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 1, 2'b01, 1);
    expect_o("ld_h0_s", C_MDO, 32'hFFFFA000, 0, 0, 0, 0, 0);

    // Byte store RMW; the word store presented during RMW_WR is ignored
    drive(0, 32'd5, 32'h0000005A, 1, 0, 2'b00, 0);
    expect_o("st_b5_c1", C_WE|C_STALL, 0, 0, 1, 0, 0, 0);
    drive(0, 32'd8, 32'hDEADBEEF, 1, 0, 2'b10, 0);
    expect_o("st_b5_c2", C_WE|C_STALL|C_ADDR|C_WDATA, 0, 1, 0, 32'd4, 32'h105A0011, 0);
    drive(0, 32'd4, 0, 0, 1, 2'b10, 0);
    expect_o("ld_after_b5", C_MDO|C_STALL, 32'h105A0011, 0, 0, 0, 0, 0);
    drive(0, 32'd8, 0, 0, 1, 2'b10, 0);
    expect_o("ld_w8_kept", C_MDO, 32'h20000022, 0, 0, 0, 0, 0);

    // Half store then back-to-back byte store on the same word
    drive(0, 32'd14, 32'h1234BEEF, 1, 0, 2'b01, 0);
    expect_o("st_h14_c1", C_WE|C_STALL, 0, 0, 1, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 0, 2'b10, 0);
    expect_o("st_h14_c2", C_WE|C_ADDR|C_WDATA|C_STALL, 0, 1, 0, 32'd12, 32'h3000BEEF, 0);
    drive(0, 32'd12, 32'h00000077, 1, 0, 2'b00, 0);
    expect_o("st_b12_c1", C_WE|C_STALL, 0, 0, 1, 0, 0, 0);
    drive(0, 32'd0, 0, 0, 0, 2'b10, 0);
    expect_o("st_b12_c2", C_WE|C_ADDR|C_WDATA, 0, 1, 0, 32'd12, 32'h7700BEEF, 0);
    drive(0, 32'd12, 0, 0, 1, 2'b10, 0);
    expect_o("ld_w12", C_MDO, 32'h7700BEEF, 0, 0, 0, 0, 0);

    // Reset asserted during RMW_WR drops the write
    drive(0, 32'd13, 32'h00000011, 1, 0, 2'b00, 0);
    expect_o("st_b13_c1", C_STALL, 0, 0, 1, 0, 0, 0);
    drive(1, 32'd0, 0, 0, 0, 2'b10, 0);
    expect_o("rst_mid_rmw", C_WE|C_STALL|C_MDO, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 32'd12, 0, 0, 1, 2'b10, 0);
    expect_o("ld_w12_after_rst", C_MDO|C_STALL|C_WE, 32'h7700BEEF, 0, 0, 0, 0, 0);

    // Misaligned word store
`ifdef MISALIGN_TRAP_EN
    drive(0, 32'd6, 32'hCAFEF00D, 1, 0, 2'b10, 0);
    expect_o("st_w6_trap", C_WE|C_ERR|C_STALL, 0, 0, 0, 0, 0, 1);
    drive(0, 32'd4, 0, 0, 1, 2'b10, 0);
    expect_o("ld_w4_unchanged", C_MDO|C_ERR, 32'h105A0011, 0, 0, 0, 0, 0);
`else
    drive(0, 32'd6, 32'hCAFEF00D, 1, 0, 2'b10, 0);
    expect_o("st_w6", C_WE|C_ERR|C_ADDR|C_WDATA|C_STALL, 0, 1, 0, 32'd4, 32'hCAFEF00D, 0);
    drive(0, 32'd4, 0, 0, 1, 2'b10, 0);
    expect_o("ld_w4_new", C_MDO|C_ERR, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    drive(0, 32'd3, 0, 0, 1, 2'b01, 1);
    expect_o("ld_h3_off1", C_MDO|C_ERR, 32'h000000AA, 0, 0, 0, 0, 0);
`endif

    drive(0, 32'd0, 0, 0, 0, 2'b10, 0);
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Byte/halfword/word load-store formatter between the EX/MEM pipeline register and the word-organised `dataMemory`. It aligns addresses and extracts and sign- or zero-extends sub-word load data. Sub-word stores run as a two-cycle read-modify-write, and the unit stalls the pipeline while one is in progress. Big-endian byte lanes: offset 0 is bits [31:24].

## Interface
Parameters:
- `AW`, 32, address width; only `[AW-1:2]` reaches memory.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mr`  in  32  effective byte address (ALU result).
- `mqb`  in  32  store data.
- `mwmem`  in  1  store request.
- `mm2reg`  in  1  load request. `mwmem` and `mm2reg` are never both 1 in one cycle.
- `msize`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `msign`  in  1  loads: 1 sign-extends, 0 zero-extends.
- `dm_addr`  out  32  word-aligned address to `dataMemory` (`mr` input).
- `dm_wdata`  out  32  write data to `dataMemory` (`mqb` input).
- `dm_we`  out  1  write enable to `dataMemory` (`mwmem` input); memory commits on the falling edge of `clk`.
- `dm_rdata`  in  32  combinational read data from `dataMemory` (`mdo`).
- `mdo`  out  32  formatted load result to MEM/WB.
- `mstall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM for the current cycle.
- `maddr_err`  out  1  misaligned-access flag; only with `MISALIGN_TRAP_EN`.

## Operation
- `off = mr[1:0]`.
- `dm_addr = {mr[31:2],2'b00}` in IDLE; in `RMW_WR` it is the latched `addr_q`.
- Byte lane k occupies bits `[31-8k -: 8]`. Halfword at offset 0 occupies `[31:16]`; at offset 2 it occupies `[15:0]`.
- Loads, fully combinational with no stall:
  - The selected lane is taken from `dm_rdata` and extended per `msign`.
  - Word loads pass `dm_rdata` through unchanged.
  - When `mm2reg=0`, `mdo = dm_rdata` unformatted; MEM/WB ignores it.
- FSM states are IDLE and RMW_WR.
- IDLE, word store: `dm_we=1` and `dm_wdata=mqb` in the same cycle; `mstall=0`; stay in IDLE.
- IDLE, byte/half store:
  - `dm_we=0`, `mstall=1`.
  - On the rising edge, `merge_q` latches `dm_rdata` with the addressed lane(s) replaced by `mqb[7:0]` / `mqb[15:0]`.
  - `addr_q` latches `dm_addr`.
  - Next state is RMW_WR.
- RMW_WR:
  - `dm_we=1`, `dm_wdata=merge_q`, `dm_addr=addr_q`, `mstall=0`.
  - The EX/MEM inputs are ignored this cycle; no new request is accepted.
  - Next state is always IDLE.
- IDLE with no request: `dm_we=0`, `mstall=0`.
- Back-to-back sub-word stores: each costs 2 cycles. The second store's read happens after the first store's falling-edge write, so it sees merged data.
- Load after sub-word store to the same word: the load executes after the write commits and returns the new data.

## Timing
- Reset (async, while `rst=1`):
  - State is IDLE; `merge_q` and `addr_q` are 0.
  - `dm_we=0` (gated by `rst`, including word stores), `mstall=0`, `maddr_err=0`, `mdo=0`.
- Reset asserted during RMW_WR: the pending write is dropped, and memory is unchanged when the write is aborted before that cycle's falling edge.
- Load latency: 0 cycles; `mdo` is valid in the same cycle as `mr`.
- Word store: 1 cycle. Sub-word store: 2 cycles, with `mstall` high for exactly the first cycle.
- `mstall` is a combinational function of the state and the inputs; it never stays high for 2 consecutive cycles.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - `maddr_err=1` combinationally when a word access has `off≠0` or a half access has `off[0]=1` (load or store).
  - A misaligned store forces `dm_we=0` and does not enter RMW_WR.
  - A misaligned load drives `mdo=0`.
- `MISALIGN_TRAP_EN` undefined:
  - `maddr_err` is tied to 0.
  - Word accesses ignore `off`.
  - Half accesses use `off[1]` only.

## Test plan
- Word load: memory word 8 = 0x20000022; `mm2reg=1`, `msize=10`, `mr=8` -> `mdo=0x20000022`, `mstall=0`, `dm_we=0`.
- Byte and half loads from word 0 = 0xA00000AA:
  - `mr=0`, byte, `msign=1` -> `mdo=0xFFFFFFA0`.
  - `mr=0`, byte, `msign=0` -> `mdo=0x000000A0`.
  - `mr=2`, half, `msign=1` -> `mdo=0x000000AA`.
- Byte store RMW:
  - Word 4 = 0x10000011; `mwmem=1`, byte, `mr=5`, `mqb=0x5A`.
  - -> cycle 1: `mstall=1`, `dm_we=0`.
  - -> cycle 2: `dm_we=1`, `dm_addr=4`, `dm_wdata=0x105A0011`.
  - -> following word load `mr=4` returns 0x105A0011.
- Half store:
  - Word 12 = 0x30000033; half, `mr=14`, `mqb=0x1234BEEF`.
  - -> cycle 2: `dm_wdata=0x3000BEEF`.
  - -> back-to-back byte store `mr=12`, `mqb=0x77` -> final word is 0x7700BEEF.
- Reset mid-RMW:
  - Assert `rst` in RMW_WR before the falling edge -> `dm_we=0` immediately, state IDLE, `mstall=0`.
  - Word 12 remains at its pre-store value.
- Misalignment:
  - With `MISALIGN_TRAP_EN`: word store `mr=6` -> `maddr_err=1`, `dm_we=0`, memory unchanged.
  - Without `MISALIGN_TRAP_EN`: the same store writes word 4 and `maddr_err=0`.
